// File: rtl/mono_pkg.sv
// Shared constants for the monochrome mode controller and the display stage
// that consumes its mode select.
package mono_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_COLOR = 2'd0;
    localparam mode_t MODE_GREEN = 2'd1;
    localparam mode_t MODE_AMBER = 2'd2;
    localparam mode_t MODE_GREY  = 2'd3;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_SCRLK = 8'h7E;

    localparam int TMO_W = 20;

    typedef enum logic [1:0] {
        KB_IDLE = 2'd0,
        KB_E0   = 2'd1,
        KB_F0   = 2'd2,
        KB_E0F0 = 2'd3
    } kb_state_t;

    // Modes cycle colour -> green -> amber -> grey -> colour.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/ps2_hotkey_detect.sv
// Scroll Lock hotkey decoder for PS/2 set-2 bytes; emits one advance pulse per
// physical key press, ignoring typematic repeats and the E0-prefixed variants.
module ps2_hotkey_detect
    import mono_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_kb_code,
    input  logic       i_kb_strobe,
    output logic       o_advance
);

    kb_state_t r_state;
    kb_state_t w_state_next;
    logic      w_make;
    logic      w_break;
    logic      r_key_down;
    logic      r_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= KB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_make       = 1'b0;
        w_break      = 1'b0;
        if (i_kb_strobe) begin
            case (r_state)
                KB_IDLE: begin
                    if (i_kb_code == SC_E0) begin
                        w_state_next = KB_E0;
                    end else if (i_kb_code == SC_F0) begin
                        w_state_next = KB_F0;
                    end else begin
                        w_state_next = KB_IDLE;
                        w_make       = (i_kb_code == SC_SCRLK);
                    end
                end
                // E0 7E belongs to Ctrl+Break, so only E0 F0 keeps the prefix alive.
                KB_E0: begin
                    w_state_next = (i_kb_code == SC_F0) ? KB_E0F0 : KB_IDLE;
                end
                KB_F0: begin
                    w_state_next = KB_IDLE;
                    w_break      = (i_kb_code == SC_SCRLK);
                end
                KB_E0F0: begin
                    w_state_next = KB_IDLE;
                end
                default: begin
                    w_state_next = KB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_down <= 1'b0;
            r_advance  <= 1'b0;
        end else begin
            r_advance <= w_make && !r_key_down;
            if (w_make) begin
                r_key_down <= 1'b1;
            end else if (w_break) begin
                r_key_down <= 1'b0;
            end
        end
    end

    assign o_advance = r_advance;

endmodule

// File: rtl/mono_mode_ctrl.sv
// Monochrome video path select: stages hotkey/CPU mode requests and applies them
// on the vsync leading edge, or continuously once vsync has been missing too long.
module mono_mode_ctrl
    import mono_pkg::*;
#(
    parameter bit          VSYNC_ACTIVE   = 1'b0,
    parameter mode_t       RESET_MODE     = MODE_COLOR,
    parameter int unsigned TIMEOUT_CYCLES = 1_048_575
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic [7:0] kb_code,
    input  logic       kb_strobe,
    input  logic       io_wr,
    input  logic [1:0] io_data,
    input  logic       vga_vsync,
    output logic [1:0] monochrome_switcher,
    output logic       mode_pending
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic             w_advance;
    mode_t            r_pend_mode;
    mode_t            r_mode;
    logic             r_vsync_prev;
    logic             w_vsync_edge;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_timeout;

    ps2_hotkey_detect u_hotkey (
        .clk         (clk_vga),
        .rst         (rst),
        .i_kb_code   (kb_code),
        .i_kb_strobe (kb_strobe),
        .o_advance   (w_advance)
    );

    // A CPU write is an absolute request, so it overrides a relative hotkey step.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_pend_mode <= RESET_MODE;
        end else if (io_wr) begin
            r_pend_mode <= io_data;
        end else if (w_advance) begin
            r_pend_mode <= next_mode(r_pend_mode);
        end
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_vsync_prev <= ~VSYNC_ACTIVE;
        end else begin
            r_vsync_prev <= vga_vsync;
        end
    end

    assign w_vsync_edge = (vga_vsync == VSYNC_ACTIVE) && (r_vsync_prev != VSYNC_ACTIVE);
    assign w_timeout    = (r_tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_vsync_edge) begin
            r_tmo_cnt <= '0;
        end else if (!w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Uses the registered staged mode, so a same-cycle request waits for the next edge.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_mode <= RESET_MODE;
        end else if (w_vsync_edge || w_timeout) begin
            r_mode <= r_pend_mode;
        end
    end

    assign monochrome_switcher = r_mode;
    assign mode_pending        = (r_pend_mode != r_mode);

endmodule

// File: tb/tb_mono_mode_ctrl.sv
// Bench for mono_mode_ctrl: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a sequence-level reference model on two instances.
module tb_mono_mode_ctrl;
    import mono_pkg::*;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kb_code;
    logic       kb_strobe;
    logic       io_wr;
    logic [1:0] io_data;
    logic       vs_act;
    logic       vs0;
    logic       vs1;
    logic [1:0] sw0;
    logic [1:0] sw1;
    logic       pend0;
    logic       pend1;

    assign vs0 = ~vs_act;
    assign vs1 = vs_act;

    always #5 clk = ~clk;

    mono_mode_ctrl #(
        .VSYNC_ACTIVE   (1'b0),
        .RESET_MODE     (MODE_COLOR),
        .TIMEOUT_CYCLES (T)
    ) u_dut0 (
        .clk_vga             (clk),
        .rst                 (rst),
        .kb_code             (kb_code),
        .kb_strobe           (kb_strobe),
        .io_wr               (io_wr),
        .io_data             (io_data),
        .vga_vsync           (vs0),
        .monochrome_switcher (sw0),
        .mode_pending        (pend0)
    );

    mono_mode_ctrl #(
        .VSYNC_ACTIVE   (1'b1),
        .RESET_MODE     (MODE_AMBER),
        .TIMEOUT_CYCLES (T)
    ) u_dut1 (
        .clk_vga             (clk),
        .rst                 (rst),
        .kb_code             (kb_code),
        .kb_strobe           (kb_strobe),
        .io_wr               (io_wr),
        .io_data             (io_data),
        .vga_vsync           (vs1),
        .monochrome_switcher (sw1),
        .mode_pending        (pend1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes since the last complete code, per-instance modes.
    logic [7:0] m_seq[$];
    bit         m_key_down;
    bit         m_adv;
    bit         m_prev_act;
    int         m_since;
    int         m_pend[2];
    int         m_out[2];
    int         m_rmode[2] = '{0, 2};

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seq.delete();
        m_key_down = 1'b0;
        m_adv      = 1'b0;
        m_prev_act = 1'b0;
        m_since    = 0;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = m_rmode[i];
            m_out[i]  = m_rmode[i];
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_sw0"},   int'(sw0),   m_out[0]);
        chk({tag, "_pend0"}, int'(pend0), int'(m_pend[0] != m_out[0]));
        chk({tag, "_sw1"},   int'(sw1),   m_out[1]);
        chk({tag, "_pend1"}, int'(pend1), int'(m_pend[1] != m_out[1]));
    endtask

    // One clock of behaviour, from the inputs present at the edge.
    task automatic model_step();
        bit edge_seen;
        bit adv_next;
        edge_seen = vs_act && !m_prev_act;
        adv_next  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (edge_seen || m_since >= T) m_out[i] = m_pend[i];
            if (io_wr)      m_pend[i] = int'(io_data);
            else if (m_adv) m_pend[i] = (m_pend[i] + 1) % 4;
        end
        m_since    = edge_seen ? 0 : ((m_since < T) ? m_since + 1 : T);
        m_prev_act = vs_act;
        if (kb_strobe) begin
            m_seq.push_back(kb_code);
            if (m_seq.size() == 1 && m_seq[0] == 8'h7E) begin
                if (!m_key_down) adv_next = 1'b1;
                m_key_down = 1'b1;
                m_seq.delete();
            end else if (m_seq.size() == 2 && m_seq[0] == 8'hF0 && m_seq[1] == 8'h7E) begin
                m_key_down = 1'b0;
                m_seq.delete();
            end else if (!((m_seq.size() == 1 && (m_seq[0] == 8'hE0 || m_seq[0] == 8'hF0)) ||
                           (m_seq.size() == 2 && m_seq[0] == 8'hE0 && m_seq[1] == 8'hF0))) begin
                m_seq.delete();
            end
        end
        m_adv = adv_next;
    endtask

    task automatic cyc(input string tag, input bit strb, input logic [7:0] code,
                       input bit wr, input logic [1:0] d);
        kb_strobe = strb;
        kb_code   = code;
        io_wr     = wr;
        io_data   = d;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic key(input string tag, input logic [7:0] code);
        cyc(tag, 1'b1, code, 1'b0, 2'd0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 8'h00, 1'b0, 2'd0);
    endtask

    task automatic wr(input string tag, input logic [1:0] d);
        cyc(tag, 1'b0, 8'h00, 1'b1, d);
    endtask

    task automatic vs_pulse(input string tag);
        vs_act = 1'b1;
        idle(tag, 2);
        vs_act = 1'b0;
        idle(tag, 1);
    endtask

    task automatic do_reset();
        kb_strobe = 1'b0;
        io_wr     = 1'b0;
        rst       = 1'b1;
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int pos;
        int flen;
        int r;
        logic [7:0] rc;
        rst       = 1'b1;
        kb_code   = 8'h00;
        kb_strobe = 1'b0;
        io_wr     = 1'b0;
        io_data   = 2'd0;
        vs_act    = 1'b0;
        #1;
        do_reset();
        chk("reset_sw0_const", int'(sw0), 0);
        chk("reset_pend0_const", int'(pend0), 0);

        // Press/release then an edge: staged immediately, applied one cycle after the edge.
        key("press", 8'h7E);
        key("press", 8'hF0);
        key("press", 8'h7E);
        chk("press_staged", int'(pend0), 1);
        chk("press_not_applied", int'(sw0), 0);
        vs_act = 1'b1;
        idle("edge", 1);
        chk("edge_applied", int'(sw0), 1);
        vs_act = 1'b0;
        idle("edge", 1);

        // Typematic repeats count once; E0-prefixed variants are ignored.
        key("rep", 8'h7E); key("rep", 8'h7E); key("rep", 8'h7E);
        key("rep", 8'hF0); key("rep", 8'h7E);
        key("e0", 8'hE0); key("e0", 8'h7E);
        key("e0", 8'hE0); key("e0", 8'hF0); key("e0", 8'h7E);
        idle("rep", 2);
        chk("rep_single_adv", int'(pend0), 1);

        // Wrap from grey through four presses.
        wr("wrap_set", 2'd3);
        vs_pulse("wrap_set");
        for (int k = 0; k < 4; k++) begin
            key("wrap", 8'h7E); key("wrap", 8'hF0); key("wrap", 8'h7E);
        end
        idle("wrap", 2);
        chk("wrap_out", int'(sw0), 3);
        chk("wrap_pending", int'(pend0), 0);

        // io_wr coinciding with the registered advance wins.
        key("simul", 8'h7E);
        wr("simul", 2'd2);
        key("simul", 8'hF0);
        key("simul", 8'h7E);
        chk("simul_pending", int'(pend0), 1);
        vs_pulse("simul");
        chk("simul_out", int'(sw0), 2);

        // io_wr on the edge cycle lands on the following edge.
        wr("edgewr", 2'd1);
        vs_pulse("edgewr");
        vs_act = 1'b1;
        wr("edgewr", 2'd2);
        chk("edgewr_old", int'(sw0), 1);
        vs_act = 1'b0;
        idle("edgewr", 2);
        vs_pulse("edgewr");
        chk("edgewr_new", int'(sw0), 2);

        // No vsync: the staged mode is forced after the timeout.
        wr("tmo", 2'd3);
        idle("tmo", T - 10);
        chk("tmo_wait", int'(sw0), 2);
        idle("tmo", 15);
        chk("tmo_forced", int'(sw0), 3);
        wr("tmo", 2'd0);
        idle("tmo", 1);
        chk("tmo_track", int'(sw0), 0);

        // Reset after F0: the next 7E decodes as a fresh make.
        key("midrst", 8'hF0);
        do_reset();
        key("midrst", 8'h7E);
        idle("midrst", 1);
        chk("midrst_adv", int'(pend0), 1);
        vs_pulse("midrst");
        chk("midrst_apply0", int'(sw0), 1);
        chk("midrst_apply1", int'(sw1), 3);

        // Randomized traffic with occasional long vsync gaps and resets.
        pos  = 0;
        flen = 40;
        for (int n = 0; n < 4000; n++) begin
            vs_act = (pos < 3);
            pos++;
            if (pos >= flen) begin
                pos  = 0;
                flen = ($urandom_range(0, 7) == 0) ? 250 : int'($urandom_range(20, 60));
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                r  = int'($urandom_range(0, 4));
                rc = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 4) ? 8'($urandom) : 8'h7E;
                cyc("rand", ($urandom_range(0, 2) == 0), rc,
                    ($urandom_range(0, 19) == 0), 2'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
